// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and stall controller for a 5-stage MIPS pipeline (F,D,E,M,W).
// Drives the forwarding selects and the pipeline register hold/clear controls.
// Resolves load-use and branch-compare stalls and multi-cycle mul/div occupancy of E.
// An exception in M flushes the pipeline and overrides every stall.
// stall_cnt is a saturating count of fetch-stall cycles for performance monitoring.
module hazard_ctrl #(
    parameter int REGW    = 5,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [REGW-1:0]  i_rs_d,
    input  logic [REGW-1:0]  i_rt_d,
    input  logic [REGW-1:0]  i_rs_e,
    input  logic [REGW-1:0]  i_rt_e,
    input  logic [REGW-1:0]  i_writereg_e,
    input  logic [REGW-1:0]  i_writereg_m,
    input  logic [REGW-1:0]  i_writereg_w,
    input  logic             i_regwrite_e,
    input  logic             i_regwrite_m,
    input  logic             i_regwrite_w,
    input  logic             i_memtoreg_e,
    input  logic             i_memtoreg_m,
    input  logic             i_branch_d,
    input  logic             i_divstart_e,
    input  logic             i_exc_m,
    output logic [1:0]       o_forward_ae,
    output logic [1:0]       o_forward_be,
    output logic             o_forward_ad,
    output logic             o_forward_bd,
    output logic             o_stall_f,
    output logic             o_stall_d,
    output logic             o_stall_e,
    output logic             o_flush_d,
    output logic             o_flush_e,
    output logic             o_flush_m,
    output logic             o_div_busy,
    output logic [CNT_W-1:0] o_stall_cnt
);

    // Counter is loaded with DIV_LAT-1, so $clog2(DIV_LAT) bits always suffice.
    localparam int                DCNT_W    = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;
    localparam logic [DCNT_W-1:0] DCNT_LOAD = DCNT_W'(DIV_LAT - 1);
    localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);
    localparam logic [DCNT_W-1:0] DCNT_ZERO = {DCNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [REGW-1:0]   REG_ZERO  = {REGW{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    // Source register hits a live destination; register 0 is hard-wired and never matches.
    function automatic logic f_hit(input logic [REGW-1:0] src,
                                   input logic [REGW-1:0] dst,
                                   input logic            we);
        return (src != REG_ZERO) && (src == dst) && we;
    endfunction

    // Either D-stage source names the given non-zero destination.
    function automatic logic f_d_uses(input logic [REGW-1:0] dst,
                                      input logic [REGW-1:0] rs,
                                      input logic [REGW-1:0] rt);
        return (dst != REG_ZERO) && ((dst == rs) || (dst == rt));
    endfunction

    div_state_t        r_state;
    div_state_t        w_state_nxt;
    logic [DCNT_W-1:0] r_div_cnt;
    logic [DCNT_W-1:0] w_div_cnt_nxt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              w_div_start;
    logic              w_divstall;
    logic              w_div_busy;
    logic              w_lwstall;
    logic              w_brstall;
    logic              w_stall_any;
    logic              w_stall_f;
    logic              w_stall_e;
    logic              w_flush_e;
    logic [1:0]        w_fwd_ae;
    logic [1:0]        w_fwd_be;

    // E-stage forwarding selects: M result has priority over W result.
    always_comb begin
        w_fwd_ae = 2'b00;
        w_fwd_be = 2'b00;
        if (f_hit(i_rs_e, i_writereg_m, i_regwrite_m)) begin
            w_fwd_ae = 2'b10;
        end else if (f_hit(i_rs_e, i_writereg_w, i_regwrite_w)) begin
            w_fwd_ae = 2'b01;
        end else begin
            w_fwd_ae = 2'b00;
        end
        if (f_hit(i_rt_e, i_writereg_m, i_regwrite_m)) begin
            w_fwd_be = 2'b10;
        end else if (f_hit(i_rt_e, i_writereg_w, i_regwrite_w)) begin
            w_fwd_be = 2'b01;
        end else begin
            w_fwd_be = 2'b00;
        end
    end

    // Load-use and branch-compare hazards detected in D.
    always_comb begin
        w_lwstall = i_memtoreg_e && (i_rt_e != REG_ZERO) &&
                    ((i_rs_d == i_rt_e) || (i_rt_d == i_rt_e));
        w_brstall = i_branch_d &&
                    ((i_regwrite_e && f_d_uses(i_writereg_e, i_rs_d, i_rt_d)) ||
                     (i_memtoreg_m && f_d_uses(i_writereg_m, i_rs_d, i_rt_d)));
    end

    // Mul/div FSM state and occupancy counter register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_div_cnt <= DCNT_ZERO;
        end else begin
            r_state   <= w_state_nxt;
            r_div_cnt <= w_div_cnt_nxt;
        end
    end

    // Mul/div next state: an exception aborts the operation and returns to IDLE.
    always_comb begin
        w_state_nxt   = r_state;
        w_div_cnt_nxt = r_div_cnt;
        case (r_state)
            ST_IDLE: begin
                if (i_divstart_e && !i_exc_m) begin
                    w_state_nxt   = ST_BUSY;
                    w_div_cnt_nxt = DCNT_LOAD;
                end else begin
                    w_state_nxt   = ST_IDLE;
                    w_div_cnt_nxt = DCNT_ZERO;
                end
            end
            ST_BUSY: begin
                if (i_exc_m) begin
                    w_state_nxt   = ST_IDLE;
                    w_div_cnt_nxt = DCNT_ZERO;
                end else if (r_div_cnt == DCNT_ONE) begin
                    w_state_nxt   = ST_DONE;
                    w_div_cnt_nxt = DCNT_ZERO;
                end else begin
                    w_state_nxt   = ST_BUSY;
                    w_div_cnt_nxt = r_div_cnt - DCNT_ONE;
                end
            end
            ST_DONE: begin
                // Result is consumed this cycle; divstartE is still the same instruction.
                w_state_nxt   = ST_IDLE;
                w_div_cnt_nxt = DCNT_ZERO;
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_div_cnt_nxt = DCNT_ZERO;
            end
        endcase
    end

    // Mul/div outputs: E is held from the launch cycle through the last BUSY cycle.
    always_comb begin
        w_div_start = 1'b0;
        w_divstall  = 1'b0;
        w_div_busy  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_div_start = i_divstart_e && !i_exc_m;
                w_divstall  = w_div_start;
                // Busy is raised in the launch cycle so the unit reads busy for its whole occupancy.
                w_div_busy  = w_div_start;
            end
            ST_BUSY: begin
                w_divstall = 1'b1;
                w_div_busy = 1'b1;
            end
            ST_DONE: begin
                w_divstall = 1'b0;
                w_div_busy = 1'b1;
            end
            default: begin
                w_divstall = 1'b0;
                w_div_busy = 1'b0;
            end
        endcase
    end

    // Stage hold/clear controls; an exception in M wins over every stall.
    always_comb begin
        w_stall_any = w_lwstall || w_brstall || w_divstall;
        if (i_exc_m) begin
            w_stall_f = 1'b0;
            w_stall_e = 1'b0;
            w_flush_e = 1'b1;
        end else begin
            w_stall_f = w_stall_any;
            w_stall_e = w_divstall;
            // While mul/div holds E, E must keep its instruction rather than take a bubble.
            w_flush_e = (w_lwstall || w_brstall) && !w_divstall;
        end
    end

    // Saturating count of fetch-stall cycles; only reset clears it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cnt <= CNT_ZERO;
        end else if (w_stall_f && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    // Drive module outputs.
    always_comb begin
        o_forward_ae = w_fwd_ae;
        o_forward_be = w_fwd_be;
        o_forward_ad = f_hit(i_rs_d, i_writereg_m, i_regwrite_m);
        o_forward_bd = f_hit(i_rt_d, i_writereg_m, i_regwrite_m);
        o_stall_f    = w_stall_f;
        o_stall_d    = w_stall_f;
        o_stall_e    = w_stall_e;
        o_flush_d    = i_exc_m;
        o_flush_e    = w_flush_e;
        o_flush_m    = i_exc_m;
        o_div_busy   = w_div_busy;
        o_stall_cnt  = r_stall_cnt;
    end

endmodule
